// File: rtl/evt_gen_pkg.sv
// ---------------------------------------------------------------------------
// evt_gen_pkg
// Shared types and default widths for the burst event generator.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package evt_gen_pkg;

  localparam int EVT_GEN_PERIOD_W = 32;
  localparam int EVT_GEN_BURST_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } evt_gen_state_t;

endpackage

`default_nettype wire

// File: rtl/period_timer.sv
// ---------------------------------------------------------------------------
// period_timer
// Loadable down-counter that spaces pulses inside a burst. It stops at zero
// and reports zero_out, so it can never underflow.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module period_timer
  import evt_gen_pkg::*;
#(
  parameter int W = EVT_GEN_PERIOD_W
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         load_in,
  input  logic [W-1:0] value_in,
  input  logic         en_in,
  output logic         zero_out
);

  logic [W-1:0] count_q;

  // Load has priority; otherwise count down while enabled and not yet zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else if (load_in) begin
      count_q <= value_in;
    end else if (en_in && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_out = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/evt_generator.sv
// ---------------------------------------------------------------------------
// evt_generator
// Programmable burst event generator: on start, emits N single-cycle pulses
// spaced P cycles apart, then a single-cycle done pulse.
// Optional feature macro: EVT_GEN_ABORT_EN (adds abort_in).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module evt_generator
  import evt_gen_pkg::*;
#(
  parameter int PERIOD_W = EVT_GEN_PERIOD_W,
  parameter int BURST_W  = EVT_GEN_BURST_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic [PERIOD_W-1:0] period_in,
  input  logic [BURST_W-1:0]  burst_len_in,
`ifdef EVT_GEN_ABORT_EN
  input  logic                abort_in,
`endif
  output logic                evt_out,
  output logic [BURST_W-1:0]  evt_idx_out,
  output logic                busy_out,
  output logic                done_out
);

  evt_gen_state_t      state_q;
  logic [BURST_W-1:0]  idx_q;
  logic [PERIOD_W-1:0] period_q;
  logic [BURST_W-1:0]  len_q;

  logic                abort_req;
  logic                last_pulse;
  logic                tmr_load;
  logic                tmr_en;
  logic                tmr_zero;
  logic [PERIOD_W-1:0] tmr_value;

`ifdef EVT_GEN_ABORT_EN
  assign abort_req = abort_in;
`else
  assign abort_req = 1'b0;
`endif

  // len_q is at least 1 whenever the FSM sits in PULSE, so N-1 cannot wrap there.
  assign last_pulse = (idx_q == (len_q - BURST_W'(1)));

  // The timer is only loaded on the PULSE->WAIT transition, where P >= 2.
  assign tmr_load  = (state_q == PULSE) && !abort_req && !last_pulse &&
                     (period_q != PERIOD_W'(1));
  assign tmr_value = period_q - PERIOD_W'(2);
  assign tmr_en    = (state_q == WAIT);

  period_timer #(
    .W (PERIOD_W)
  ) u_period_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load_in  (tmr_load),
    .value_in (tmr_value),
    .en_in    (tmr_en),
    .zero_out (tmr_zero)
  );

  // Burst control FSM with latched parameters and pulse index.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      period_q <= '0;
      len_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            period_q <= (period_in == '0) ? PERIOD_W'(1) : period_in;
            len_q    <= burst_len_in;
            if (burst_len_in == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= PULSE;
              idx_q   <= '0;
            end
          end
        end
        PULSE: begin
          if (abort_req || last_pulse) begin
            state_q <= DONE;
          end else if (period_q == PERIOD_W'(1)) begin
            idx_q <= idx_q + BURST_W'(1);
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (abort_req) begin
            state_q <= DONE;
          end else if (tmr_zero) begin
            state_q <= PULSE;
            idx_q   <= idx_q + BURST_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded purely from registered state.
  assign evt_out     = (state_q == PULSE);
  assign evt_idx_out = idx_q;
  assign busy_out    = (state_q == PULSE) || (state_q == WAIT);
  assign done_out    = (state_q == DONE);

endmodule

`default_nettype wire

// File: doc/evt_generator.md
# evt_generator

Programmable burst event generator: on a start request it emits a burst of `burst_len_in` single-cycle `evt_out` pulses spaced `period_in` clock cycles apart, then signals completion. It drives the transmit side of the sonar front end (transducer trigger ticks, chirp sample strobes) and is the producer matching the event counters on the receive path. Its `evt_out` connects directly to any counter's `evt_in`.

## Interface
- `PERIOD_W`, default 32: width of `period_in` and of the internal period timer.
- `BURST_W`, default 16: width of `burst_len_in` and of `evt_idx_out`.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset. Asynchronous, active-high.
- `start_in` in 1: start request. Sampled only in IDLE.
- `period_in` in `PERIOD_W`: cycles between pulse rising edges. Latched at start. A value of 0 is treated as 1.
- `burst_len_in` in `BURST_W`: number of pulses in the burst. Latched at start.
- `abort_in` in 1: abort request. Present only with `EVT_GEN_ABORT_EN`.
- `evt_out` out 1: single-cycle event pulse.
- `evt_idx_out` out `BURST_W`: 0-based index of the current pulse. Valid when `evt_out` is high; holds its last value otherwise.
- `busy_out` out 1: high while a burst is in progress.
- `done_out` out 1: single-cycle completion pulse.

## Operation
- **States:** IDLE, PULSE, WAIT, DONE.
- **IDLE**
  - If `start_in` = 1: latch the period P (forced to ≥1) and the burst length N.
  - If N = 0 → DONE. Otherwise → PULSE with index 0.
- **PULSE**
  - `evt_out` = 1 and `evt_idx_out` = index.
  - If index = N−1 → DONE.
  - Else if P = 1 → PULSE with index+1.
  - Else → WAIT with timer = P−2.
- **WAIT**
  - If timer = 0 → PULSE with index+1.
  - Else decrement the timer.
- **DONE:** `done_out` = 1, then → IDLE.
- `busy_out` = 1 in PULSE and WAIT only.
- `start_in` is ignored outside IDLE, including in DONE. No queueing.
- Input changes on `period_in` / `burst_len_in` after start have no effect on the running burst.
- **Arithmetic**
  - Index counter is `BURST_W` wide. It never wraps, because the maximum index is N−1 ≤ 2^`BURST_W`−2.
  - Timer is `PERIOD_W` wide, unsigned, and never underflows.
- **Reset (any state):** on `rst_in` assertion, all outputs go to 0 immediately and state → IDLE. Latched P, N, timer and index are cleared to 0.
- All outputs are registered or decoded from state registers only. No combinational path from inputs to outputs.

## Timing
- `start_in` accepted at edge t → first `evt_out` at cycle t+1.
- Pulse k is at cycle t+1+k·P.
- `done_out` fires one cycle after the last pulse: cycle t+1+(N−1)·P+1.
- `busy_out` is high from cycle t+1 through the last pulse cycle. It is low in the same cycle `done_out` is high.
- N = 0: `done_out` at t+1; `busy_out` never asserts.
- Earliest next start: the cycle after `done_out`. Back-to-back bursts therefore have a 1-cycle gap after DONE.
- P = 1: `evt_out` is continuously high for N cycles. `evt_idx_out` increments every cycle.

## Configuration
- **`EVT_GEN_ABORT_EN` defined**
  - Port `abort_in` exists.
  - `abort_in` = 1 in PULSE or WAIT → DONE on the next edge. `done_out` pulses and no further `evt_out` is emitted.
  - A pulse in the same cycle as the abort has already been emitted and is counted.
  - `abort_in` is ignored in IDLE and DONE.
  - If `abort_in` and `rst_in` are asserted together, reset wins.
- **`EVT_GEN_ABORT_EN` undefined:** `abort_in` port is absent. Bursts always run to completion or until reset.

## Structure
- **Package `evt_gen_pkg`:**
  - State enum `evt_gen_state_t` (IDLE, PULSE, WAIT, DONE).
  - Default width localparams `EVT_GEN_PERIOD_W` = 32 and `EVT_GEN_BURST_W` = 16.
- **Sub-module `period_timer`:**
  - Loadable down-counter with async reset.
  - Inputs: load, value, enable. Output: `zero_out`.
  - Instantiated once for the WAIT timing.
- The FSM and index counter live in `evt_generator`.

## Test plan
- **Basic burst:** P = 4, N = 3, start at cycle 0 → `evt_out` at cycles 1, 5, 9 with `evt_idx_out` 0, 1, 2. `done_out` at 10. `busy_out` high for cycles 1–9.
- **Edge periods:** P = 0 and P = 1, N = 4 → `evt_out` high for cycles 1–4 continuously with index 0–3. `done_out` at 5.
- **Empty burst:** N = 0 → no `evt_out`, `done_out` at cycle 1, `busy_out` never high.
- **Ignored start and input changes:** pulse `start_in` while busy and change `period_in` mid-burst → burst unchanged, no second burst. A start in the cycle after `done_out` is accepted.
- **Reset mid-burst:** async `rst_in` during WAIT of a P = 10, N = 5 burst → all outputs 0 immediately, no `done_out`. A new start after release behaves normally.
- **Abort (`EVT_GEN_ABORT_EN`):** P = 4, N = 5, abort in cycle 6 → pulses at 1 and 5 only, `done_out` at 7, then IDLE.
